// File: rtl/mips_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state, port owner,
// big-endian 4-byte word and default timing constants.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    // Byte 0 is the most significant byte, so a byte4_t maps straight onto a
    // big-endian 32-bit word.
    typedef logic [0:3][7:0] byte4_t;

    localparam int MEM_LATENCY_DEF = 4;
    localparam int IWAIT_MAX_DEF   = 2;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and shared-memory signals of the arbiter; slave is the arbiter side,
// master is the side of the fetch unit, the data cache and the memory.
interface mem_arbiter_if;
    import mips_pkg::*;

    logic          i_req;
    logic [31:0]   i_addr;
    logic [31:0]   i_rdata;
    logic          i_ready;

    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    byte4_t        d_wdata;
    byte4_t        d_rdata;
    logic          d_ready;

    logic [31:0]   m_addr;
    byte4_t        m_wdata;
    logic          m_we;
    byte4_t        m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ready, d_rdata, d_ready, m_addr, m_wdata, m_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready, m_addr, m_wdata, m_we
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between instruction fetch and
// the data cache; data has priority, bounded by an instruction starvation counter.
//
// state | meaning
// IDLE  | no transaction; grant on the first edge a request is present
// BUSY  | memory access in flight, address/data/we held for MEM_LATENCY cycles
// RESP  | one-cycle ready pulse to the owner, m_we low
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int IWAIT_MAX   = IWAIT_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_b,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] LAT_LOAD  = 4'(MEM_LATENCY - 1);
    localparam logic [1:0] IWAIT_LIM = 2'(IWAIT_MAX);

    arb_state_t  state_q,   state_d;
    owner_t      owner_q,   owner_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [1:0]  iwait_q,   iwait_d;
    logic [31:0] m_addr_q,  m_addr_d;
    byte4_t      m_wdata_q, m_wdata_d;
    logic        m_we_q,    m_we_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    byte4_t      d_rdata_q, d_rdata_d;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        iwait_d   = iwait_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = m_we_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                m_we_d = 1'b0;
                // Data wins unless the instruction port has already lost IWAIT_MAX times in a row.
                if (bus.d_req && (!bus.i_req || (iwait_q < IWAIT_LIM))) begin
                    owner_d   = OWN_D;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_we_d    = bus.d_we;
                    lat_cnt_d = LAT_LOAD;
                    state_d   = BUSY;
                    if (bus.i_req) begin
                        iwait_d = sat_inc2(iwait_q);
                    end
                end else if (bus.i_req) begin
                    owner_d   = OWN_I;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    m_we_d    = 1'b0;
                    lat_cnt_d = LAT_LOAD;
                    iwait_d   = 2'd0;
                    state_d   = BUSY;
                end
            end

            BUSY: begin
                if (lat_cnt_q == 4'd0) begin
                    if (owner_q == OWN_I) begin
                        i_rdata_d = bus.m_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        if (!m_we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                        d_ready_d = 1'b1;
                    end
                    m_we_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            RESP: begin
                m_we_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                m_we_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            lat_cnt_q <= 4'd0;
            iwait_q   <= 2'd0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            iwait_q   <= iwait_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_we_q    <= m_we_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_we    = m_we_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_ready = d_ready_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LATENCY=4, IWAIT_MAX=2; a small memory
// model answers every address with a known word.
module tb_mem_arbiter;
    import mips_pkg::*;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .MEM_LATENCY (4),
        .IWAIT_MAX   (2)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C01_0004 : {a[15:0], 16'hBEEF};
    endfunction

    assign bus.m_rdata = mem_word(bus.m_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one request, hold it until its ready, then drop it in the ready cycle.
    task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int rdy_at, output int we_cyc,
                       output int other_rdy, output int addr_cyc, output logic [31:0] busy_wdata);
        if (is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = addr;
        end
        rdy_at     = -1;
        we_cyc     = 0;
        other_rdy  = 0;
        addr_cyc   = 0;
        busy_wdata = '0;
        for (int k = 1; k <= 12 && rdy_at < 0; k++) begin
            step();
            if (k == 1) busy_wdata = bus.m_wdata;
            if (bus.m_we) we_cyc++;
            if (is_d ? bus.i_ready : bus.d_ready) other_rdy++;
            if (is_d ? bus.d_ready : bus.i_ready) rdy_at = k;
            else if (bus.m_addr == addr) addr_cyc++;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          rdy_at, we_cyc, other_rdy, addr_cyc, n_gr, last, cnt, cnt2;
        logic [31:0] wd;
        logic [5:0]  order;

        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        #12;
        chk("rst_m_we",    32'(bus.m_we),    32'h0);
        chk("rst_m_addr",  bus.m_addr,       32'h0);
        chk("rst_m_wdata", bus.m_wdata,      32'h0);
        chk("rst_readies", {30'd0, bus.i_ready, bus.d_ready}, 32'h0);
        chk("rst_i_rdata", bus.i_rdata,      32'h0);
        chk("rst_d_rdata", bus.d_rdata,      32'h0);

        @(negedge clk);
        rst_b = 1'b1;
        step();
        chk("idle_m_addr", bus.m_addr, 32'h0);

        // Instruction read of 0x40.
        txn(1'b0, 1'b0, 32'h40, 32'h0, rdy_at, we_cyc, other_rdy, addr_cyc, wd);
        chk("iread_rdy_at",  32'(rdy_at),    32'd5);
        chk("iread_addr_cy", 32'(addr_cyc),  32'd4);
        chk("iread_rdata",   bus.i_rdata,    32'h8C01_0004);
        chk("iread_d_rdy",   32'(other_rdy), 32'd0);
        chk("iread_we",      32'(we_cyc),    32'd0);
        step();
        chk("idle_hold_addr", bus.m_addr, 32'h40);
        chk("idle_i_rdy_lo",  32'(bus.i_ready), 32'h0);

        // Data read to give d_rdata a known value, then a write that must not disturb it.
        txn(1'b1, 1'b0, 32'h200, 32'h0, rdy_at, we_cyc, other_rdy, addr_cyc, wd);
        chk("dread_rdy_at", 32'(rdy_at), 32'd5);
        chk("dread_rdata",  bus.d_rdata, 32'h0200_BEEF);
        chk("dread_i_hold", bus.i_rdata, 32'h8C01_0004);
        step();

        txn(1'b1, 1'b1, 32'h100, 32'hAABB_CCDD, rdy_at, we_cyc, other_rdy, addr_cyc, wd);
        chk("dwr_we_cycles", 32'(we_cyc),    32'd4);
        chk("dwr_wdata",     wd,             32'hAABB_CCDD);
        chk("dwr_rdy_at",    32'(rdy_at),    32'd5);
        chk("dwr_i_rdy",     32'(other_rdy), 32'd0);
        chk("dwr_rdata_kept", bus.d_rdata,   32'h0200_BEEF);
        chk("dwr_resp_we",   32'(bus.m_we),  32'h0);
        step();

        // Both ports requesting continuously.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h80;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h300;
        order = '0;
        n_gr  = 0;
        last  = 0;
        for (int k = 1; k <= 60 && n_gr < 6; k++) begin
            step();
            if (bus.d_ready || bus.i_ready) begin
                order = {order[4:0], bus.d_ready};
                if (bus.i_ready) chk("iwait_clear", 32'(dut.iwait_q), 32'h0);
                if (n_gr > 0) chk("grant_spacing", 32'(k - last), 32'd6);
                last = k;
                n_gr++;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        chk("grant_count", 32'(n_gr), 32'd6);
        chk("grant_order", 32'(order), 32'b110110);
        step();

        // Reset in the second BUSY cycle of a data write.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h180;
        bus.d_wdata = 32'h1122_3344;
        step();
        step();
        chk("rst_pre_we", 32'(bus.m_we), 32'h1);
        #2 rst_b = 1'b0;
        #1;
        chk("rst_async_we",   32'(bus.m_we), 32'h0);
        chk("rst_async_addr", bus.m_addr,    32'h0);
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h44;
        @(negedge clk);
        rst_b = 1'b1;
        txn(1'b0, 1'b0, 32'h44, 32'h0, rdy_at, we_cyc, other_rdy, addr_cyc, wd);
        chk("post_rst_rdy_at", 32'(rdy_at),    32'd5);
        chk("post_rst_addr",   32'(addr_cyc),  32'd4);
        chk("post_rst_no_drdy", 32'(other_rdy), 32'd0);
        chk("post_rst_d_rdata", bus.d_rdata,   32'h0);
        step();

        // Back-to-back data reads, second one presented in the cycle after ready.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h100;
        rdy_at = -1;
        for (int k = 1; k <= 12 && rdy_at < 0; k++) begin
            step();
            if (bus.d_ready) rdy_at = k;
        end
        chk("b2b_first_rdy", 32'(rdy_at), 32'd5);
        bus.d_addr = 32'h104;
        rdy_at = -1;
        wd = '0;
        for (int k = 1; k <= 12 && rdy_at < 0; k++) begin
            step();
            if (k == 2) wd = bus.m_addr;
            if (bus.d_ready) rdy_at = k;
        end
        bus.d_req = 1'b0;
        chk("b2b_gap",    32'(rdy_at), 32'd6);
        chk("b2b_m_addr", wd,          32'h104);
        chk("b2b_rdata",  bus.d_rdata, 32'h0104_BEEF);
        step();

        // Instruction request dropped right after grant still completes once.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h48;
        step();
        bus.i_req = 1'b0;
        rdy_at = -1;
        cnt    = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.i_ready) begin
                cnt++;
                if (rdy_at < 0) rdy_at = k;
            end
        end
        chk("idrop_rdy_at", 32'(rdy_at), 32'd4);
        chk("idrop_pulses", 32'(cnt),    32'd1);
        chk("idrop_rdata",  bus.i_rdata, 32'h0048_BEEF);

        // One-cycle instruction pulse during a data read is never granted.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h204;
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h4C;
        step();
        bus.i_req = 1'b0;
        rdy_at = -1;
        for (int k = 1; k <= 12 && rdy_at < 0; k++) begin
            step();
            if (bus.d_ready) rdy_at = k;
        end
        bus.d_req = 1'b0;
        chk("ipulse_d_rdy_at", 32'(rdy_at), 32'd3);
        cnt  = 0;
        cnt2 = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (bus.i_ready) cnt++;
            if (bus.m_addr != 32'h204) cnt2++;
        end
        chk("ipulse_no_irdy",  32'(cnt),     32'd0);
        chk("ipulse_no_grant", 32'(cnt2),    32'd0);
        chk("ipulse_d_rdata",  bus.d_rdata,  32'h0204_BEEF);
        chk("ipulse_i_hold",   bus.i_rdata,  32'h0048_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
